// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
package uart_pkg;

  // 27 MHz core clock / 115200 baud
  localparam int DEFAULT_CLK_DIVIDE = 234;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Word must arrive zero-extended so unused upper bits do not disturb the XOR.
  function automatic logic parity_bit(input parity_e mode, input logic [8:0] word);
    return (mode == PAR_ODD) ? ~(^word) : ^word;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read; push ignored when full, pop ignored when empty.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed frame FSM with configurable data/parity/stop bits.
// TX, TX_ACTIVE and TX_DONE are registered one cycle behind the FSM state.
module uart_tx_fifo import uart_pkg::*; #(
  parameter int CLK_DIVIDE = DEFAULT_CLK_DIVIDE,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         IN_VALID,
  input  logic [DATA_BITS-1:0]         IN_DATA,
  output logic                         IN_READY,
  output logic                         TX,
  output logic                         TX_ACTIVE,
  output logic                         TX_DONE,
  output logic [$clog2(FIFO_DEPTH):0]  FIFO_COUNT
);

  localparam int      BAUD_W   = $clog2(CLK_DIVIDE);
  localparam parity_e PAR_MODE = parity_e'(PARITY);

  tx_state_e            state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 active_q, active_d;
  logic                 end_q, end_d;
  logic                 done_q;

  logic                 fifo_full, fifo_empty, pop;
  logic [DATA_BITS-1:0] head;
  logic                 baud_last, data_last, stop_last;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (CLK),
    .rst_ni      (RST),
    .push_i      (IN_VALID),
    .push_data_i (IN_DATA),
    .pop_i       (pop),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (FIFO_COUNT)
  );

  assign IN_READY  = !fifo_full;
  assign TX        = tx_q;
  assign TX_ACTIVE = active_q;
  assign TX_DONE   = done_q;

  assign baud_last = (baud_q == BAUD_W'(CLK_DIVIDE - 1));
  assign data_last = (bit_q == 4'(DATA_BITS - 1));
  assign stop_last = (bit_q == 4'(STOP_BITS - 1));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      active_q <= 1'b0;
      end_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      active_q <= active_d;
      end_q    <= end_d;
      done_q   <= end_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!fifo_empty) state_d = ST_START;
      ST_START:  if (baud_last) state_d = ST_DATA;
      ST_DATA:   if (baud_last && data_last)
                   state_d = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
      ST_PARITY: if (baud_last) state_d = ST_STOP;
      ST_STOP:   if (baud_last && stop_last)
                   state_d = fifo_empty ? ST_IDLE : ST_START;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    shift_d  = shift_q;
    par_d    = par_q;
    bit_d    = bit_q;
    tx_d     = 1'b1;
    active_d = (state_q != ST_IDLE);
    end_d    = (state_q == ST_STOP) && baud_last && stop_last;
    baud_d   = (baud_last || state_q == ST_IDLE || state_d != state_q) ? '0 : baud_q + BAUD_W'(1);
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA: begin
        tx_d = shift_q[0];
        if (baud_last) begin
          shift_d = shift_q >> 1;
          bit_d   = data_last ? '0 : bit_q + 4'd1;
        end
      end
      ST_PARITY: tx_d = par_q;
      ST_STOP:   if (baud_last) bit_d = stop_last ? '0 : bit_q + 4'd1;
      default:   ;
    endcase
    // Pop from idle, or on the final stop cycle so the next start bit follows with no gap.
    if ((state_q == ST_IDLE || end_d) && !fifo_empty) begin
      pop     = 1'b1;
      shift_d = head;
      par_d   = parity_bit(PAR_MODE, 9'(head));
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances cover 8N1, 8E1, 8O1 and 5N2 framing at divide 4.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_vld [4];
  logic [7:0] in_dat;
  logic       tx_w [4], act_w [4], done_w [4], rdy_w [4];
  logic [4:0] cnt_w [4];

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_DIVIDE(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u0 (
    .CLK(clk), .RST(rst_n), .IN_VALID(in_vld[0]), .IN_DATA(in_dat), .IN_READY(rdy_w[0]),
    .TX(tx_w[0]), .TX_ACTIVE(act_w[0]), .TX_DONE(done_w[0]), .FIFO_COUNT(cnt_w[0]));
  uart_tx_fifo #(.CLK_DIVIDE(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u1 (
    .CLK(clk), .RST(rst_n), .IN_VALID(in_vld[1]), .IN_DATA(in_dat), .IN_READY(rdy_w[1]),
    .TX(tx_w[1]), .TX_ACTIVE(act_w[1]), .TX_DONE(done_w[1]), .FIFO_COUNT(cnt_w[1]));
  uart_tx_fifo #(.CLK_DIVIDE(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u2 (
    .CLK(clk), .RST(rst_n), .IN_VALID(in_vld[2]), .IN_DATA(in_dat), .IN_READY(rdy_w[2]),
    .TX(tx_w[2]), .TX_ACTIVE(act_w[2]), .TX_DONE(done_w[2]), .FIFO_COUNT(cnt_w[2]));
  uart_tx_fifo #(.CLK_DIVIDE(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u3 (
    .CLK(clk), .RST(rst_n), .IN_VALID(in_vld[3]), .IN_DATA(in_dat[4:0]), .IN_READY(rdy_w[3]),
    .TX(tx_w[3]), .TX_ACTIVE(act_w[3]), .TX_DONE(done_w[3]), .FIFO_COUNT(cnt_w[3]));

  // Reference frame, bit 0 = start; everything past the parity bit is stop (high).
  function automatic logic [15:0] frame_bits(input logic [7:0] w, input int nb, input int par);
    logic [15:0] b;
    logic        pb;
    b    = '1;
    b[0] = 1'b0;
    pb   = 1'b0;
    for (int i = 0; i < nb; i++) begin
      b[1+i] = w[i];
      pb     = pb ^ w[i];
    end
    if (par != 0) b[1+nb] = (par == 2) ? pb : ~pb;
    return b;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++; if (tx_w[i] !== 1'b1) begin failures++; $display("FAIL reset_tx u%0d got=%b exp=1", i, tx_w[i]); end
      checks++; if (act_w[i] !== 1'b0) begin failures++; $display("FAIL reset_active u%0d got=%b exp=0", i, act_w[i]); end
      checks++; if (done_w[i] !== 1'b0) begin failures++; $display("FAIL reset_done u%0d got=%b exp=0", i, done_w[i]); end
      checks++; if (cnt_w[i] !== 5'd0) begin failures++; $display("FAIL reset_count u%0d got=%0d exp=0", i, cnt_w[i]); end
      checks++; if (rdy_w[i] !== 1'b1) begin failures++; $display("FAIL reset_ready u%0d got=%b exp=1", i, rdy_w[i]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      checks++;
      if (tx_w[0] !== 1'b1 || act_w[0] !== 1'b0 || rdy_w[0] !== 1'b1 || done_w[0] !== 1'b0) begin
        failures++;
        $display("FAIL idle_line cycle=%0d got tx=%b act=%b rdy=%b done=%b exp tx=1 act=0 rdy=1 done=0",
                 c, tx_w[0], act_w[0], rdy_w[0], done_w[0]);
        break;
      end
    end
  endtask

  task automatic test_frames();
    int         t_word [4] = '{8'h55, 8'h07, 8'h07, 8'h1F};
    int         t_nb   [4] = '{8, 8, 8, 5};
    int         t_par  [4] = '{0, 2, 1, 0};
    int         t_cyc  [4] = '{40, 44, 44, 32};
    logic [15:0] bits;
    logic [7:0]  exp_w, rx, mask;
    int          act_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_vld[i] = 1'b1;
      in_dat    = 8'(t_word[i]);
      @(posedge clk);
      exp_q.push_back(8'(t_word[i]));
      @(negedge clk);
      in_vld[i] = 1'b0;
      checks++; if (cnt_w[i] !== 5'd1) begin failures++; $display("FAIL frame_count_accept u%0d got=%0d exp=1", i, cnt_w[i]); end
      @(negedge clk);
      checks++; if (tx_w[i] !== 1'b1) begin failures++; $display("FAIL frame_tx_before_start u%0d got=%b exp=1", i, tx_w[i]); end
      checks++; if (cnt_w[i] !== 5'd0) begin failures++; $display("FAIL frame_count_pop u%0d got=%0d exp=0", i, cnt_w[i]); end
      exp_w   = exp_q.pop_front();
      bits    = frame_bits(exp_w, t_nb[i], t_par[i]);
      mask    = 8'((1 << t_nb[i]) - 1);
      act_cnt = 0;
      rx      = '0;
      for (int j = 0; j < t_cyc[i]; j++) begin
        @(negedge clk);
        if (act_w[i] === 1'b1) act_cnt++;
        checks++;
        if (tx_w[i] !== bits[j/4] || done_w[i] !== 1'b0) begin
          failures++;
          $display("FAIL frame_bit u%0d cycle=%0d got tx=%b done=%b exp tx=%b done=0", i, j, tx_w[i], done_w[i], bits[j/4]);
        end
        if (j % 4 == 2 && j / 4 >= 1 && j / 4 <= t_nb[i]) rx[j/4-1] = tx_w[i];
      end
      @(negedge clk);
      checks++; if (done_w[i] !== 1'b1) begin failures++; $display("FAIL frame_done u%0d got=%b exp=1", i, done_w[i]); end
      checks++; if (act_w[i] !== 1'b0) begin failures++; $display("FAIL frame_active_end u%0d got=%b exp=0", i, act_w[i]); end
      checks++; if (act_cnt != t_cyc[i]) begin failures++; $display("FAIL frame_active_len u%0d got=%0d exp=%0d", i, act_cnt, t_cyc[i]); end
      checks++; if (rx !== (exp_w & mask)) begin failures++; $display("FAIL frame_data u%0d got=%h exp=%h", i, rx, exp_w & mask); end
      @(negedge clk);
      checks++; if (done_w[i] !== 1'b0) begin failures++; $display("FAIL frame_done_width u%0d got=%b exp=0", i, done_w[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0, stall_at = -1, guard = 0, done_cnt = 0, t = 0;
    logic r;
    logic [7:0]  exp_w, rx;
    logic [15:0] bits;
    fork
      begin
        while (n < 20 && guard < 3000) begin
          @(negedge clk);
          guard++;
          in_vld[0] = 1'b1;
          in_dat    = 8'(n * 37 + 3);
          r         = rdy_w[0];
          if (!r && stall_at < 0) stall_at = n;
          @(posedge clk);
          if (r) begin exp_q.push_back(8'(n * 37 + 3)); n++; end
        end
        @(negedge clk);
        in_vld[0] = 1'b0;
      end
      begin
        @(negedge clk);
        while (act_w[0] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        for (int f = 0; f < 20; f++) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++; $display("FAIL stream_queue frame=%0d got=empty exp=entry", f);
            exp_w = '0;
          end else exp_w = exp_q.pop_front();
          bits = frame_bits(exp_w, 8, 0);
          rx   = '0;
          for (int j = 0; j < 40; j++) begin
            if (!(f == 0 && j == 0)) @(negedge clk);
            if (done_w[0] === 1'b1) done_cnt++;
            checks++;
            if (tx_w[0] !== bits[j/4] || act_w[0] !== 1'b1 || done_w[0] !== (j == 0 && f > 0)) begin
              failures++;
              $display("FAIL stream_bit frame=%0d cycle=%0d got tx=%b act=%b done=%b exp tx=%b act=1 done=%b",
                       f, j, tx_w[0], act_w[0], done_w[0], bits[j/4], (j == 0 && f > 0));
            end
            if (j % 4 == 2 && j / 4 >= 1 && j / 4 <= 8) rx[j/4-1] = tx_w[0];
          end
          checks++; if (rx !== exp_w) begin failures++; $display("FAIL stream_data frame=%0d got=%h exp=%h", f, rx, exp_w); end
        end
        @(negedge clk);
        if (done_w[0] === 1'b1) done_cnt++;
        checks++; if (act_w[0] !== 1'b0) begin failures++; $display("FAIL stream_active_end got=%b exp=0", act_w[0]); end
      end
    join
    checks++; if (stall_at != 17) begin failures++; $display("FAIL stream_ready_drop got=%0d exp=17", stall_at); end
    checks++; if (n != 20) begin failures++; $display("FAIL stream_accepts got=%0d exp=20", n); end
    checks++; if (done_cnt != 20) begin failures++; $display("FAIL stream_done_pulses got=%0d exp=20", done_cnt); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] w [4] = '{8'hF0, 8'h11, 8'h22, 8'h33};
    @(negedge clk);
    in_vld[0] = 1'b1;
    for (int m = 0; m < 4; m++) begin
      in_dat = w[m];
      @(posedge clk);
      @(negedge clk);
    end
    in_vld[0] = 1'b0;
    checks++; if (cnt_w[0] !== 5'd3) begin failures++; $display("FAIL rstmid_queued got=%0d exp=3", cnt_w[0]); end
    repeat (16) @(negedge clk);
    checks++; if (tx_w[0] !== 1'b0 || act_w[0] !== 1'b1) begin
      failures++; $display("FAIL rstmid_data_bit3 got tx=%b act=%b exp tx=0 act=1", tx_w[0], act_w[0]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (tx_w[0] !== 1'b1) begin failures++; $display("FAIL rstmid_tx got=%b exp=1", tx_w[0]); end
    checks++; if (cnt_w[0] !== 5'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", cnt_w[0]); end
    checks++; if (done_w[0] !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done_w[0]); end
    rst_n = 1'b1;
    exp_q.delete();
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      checks++;
      if (tx_w[0] !== 1'b1 || act_w[0] !== 1'b0 || done_w[0] !== 1'b0 || cnt_w[0] !== 5'd0) begin
        failures++;
        $display("FAIL rstmid_after cycle=%0d got tx=%b act=%b done=%b cnt=%0d exp tx=1 act=0 done=0 cnt=0",
                 c, tx_w[0], act_w[0], done_w[0], cnt_w[0]);
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_dat = '0;
    for (int i = 0; i < 4; i++) in_vld[i] = 1'b0;
    test_reset();
    test_idle();
    test_frames();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
